bus_arbiter: RTL and testbench

Round-robin arbiter sharing the single system bus (and the address decoder/chip-select logic behind it) between three bus masters: CPU instruction fetch, CPU data, and a DMA/video requester. It owns the bus-cycle sequencing. It grants one master at a time and holds the grant for that master's whole bus cycle. It routes slave acknowledge and error back to the granted master only. Optionally, it aborts cycles whose slave never acknowledges. Address, data and select muxing is done outside the block, steered by `grant_o`.

---
 rtl/bus_arbiter_if.sv | 22 ++
 rtl/bus_arbiter.sv | 104 ++++++++++
 tb/tb_bus_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the three masters, the arbiter and the slave decoder.
// The master modport is the arbiter side; slave is the environment side.
interface bus_arbiter_if;
    logic [2:0] m_cyc;
    logic [2:0] m_ack;
    logic [2:0] m_err;
    logic       s_ack;
    logic       s_err;
    logic       s_cyc;
    logic [1:0] grant;
    logic       gnt_valid;

    modport master (
        input  m_cyc, s_ack, s_err,
        output m_ack, m_err, s_cyc, grant, gnt_valid
    );

    modport slave (
        output m_cyc, s_ack, s_err,
        input  m_ack, m_err, s_cyc, grant, gnt_valid
    );
endinterface

// File: rtl/bus_arbiter.sv
// Three-master round-robin bus arbiter with grant held for the whole cycle.
// Define BUS_ARBITER_TIMEOUT_EN to add the watchdog that errors silent slaves.
module bus_arbiter #(
    parameter int TIMEOUT_BITS = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    bus_arbiter_if.master bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] grant;
    logic       gnt_valid;
    logic [1:0] winner;
    logic [2:0] idx;
    logic       cyc_held;
    logic       s_cyc;
    logic [2:0] sel;
    logic       wd_err;

    // Scan from the far end so the candidate nearest the pointer wins.
    always_comb begin
        winner = ptr;
        idx    = '0;
        for (int i = 2; i >= 0; i--) begin
            idx = {1'b0, ptr} + 3'(i);
            if (idx >= 3'd3)
                idx = idx - 3'd3;
            if (bus.m_cyc[idx])
                winner = idx[1:0];
        end
    end

    always_comb begin
        cyc_held = 1'b0;
        case (grant)
            2'd0:    cyc_held = bus.m_cyc[0];
            2'd1:    cyc_held = bus.m_cyc[1];
            2'd2:    cyc_held = bus.m_cyc[2];
            default: cyc_held = 1'b0;
        endcase
    end

    assign s_cyc = gnt_valid & cyc_held;
    assign sel   = gnt_valid ? (3'b001 << grant) : 3'b000;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            grant     <= 2'd0;
            gnt_valid <= 1'b0;
            ptr       <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.m_cyc) begin
                        grant     <= winner;
                        gnt_valid <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (!cyc_held) begin
                        gnt_valid <= 1'b0;
                        state     <= IDLE;
                        ptr       <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
                    end
                end
                default: begin
                    gnt_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] wd_cnt;

    assign wd_err = s_cyc && !bus.s_ack && !bus.s_err
                 && (wd_cnt == TIMEOUT_BITS'(TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (rst_i || !s_cyc || bus.s_ack || bus.s_err || wd_err)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    // Parameters only matter when the watchdog is built in.
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_BITS == 0) || (TIMEOUT == 0);
    assign wd_err     = 1'b0;
`endif

    assign bus.s_cyc     = s_cyc;
    assign bus.grant     = grant;
    assign bus.gnt_valid = gnt_valid;
    assign bus.m_ack     = {3{bus.s_ack}} & sel;
    assign bus.m_err     = {3{bus.s_err | wd_err}} & sel;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter.
// Inputs change and outputs are sampled just after each falling edge.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter_if bus();

    bus_arbiter #(
        .TIMEOUT_BITS(8),
        .TIMEOUT(10)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    task automatic drive(input logic [2:0] cyc, input logic ack, input logic err);
        @(negedge clk);
        bus.m_cyc = cyc;
        bus.s_ack = ack;
        bus.s_err = err;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(3'b000, 1'b0, 1'b0);
        drive(3'b000, 1'b0, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(3'b000, 1'b0, 1'b0);
            checks++;
            if (bus.gnt_valid !== 1'b0 || bus.s_cyc !== 1'b0 || bus.grant !== 2'd0
                || bus.m_ack !== 3'b000 || bus.m_err !== 3'b000) begin
                failures++;
                $display("FAIL reset_idle c%0d: gnt_valid=%b s_cyc=%b grant=%0d ack=%b err=%b want all 0",
                         c, bus.gnt_valid, bus.s_cyc, bus.grant, bus.m_ack, bus.m_err);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4];
        logic [2:0] cyc;
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd0};
        for (int k = 0; k < 4; k++) begin
            drive(3'b111, 1'b0, 1'b0);
            checks++;
            if (bus.gnt_valid !== 1'b0) begin
                failures++;
                $display("FAIL rr_dead k%0d: gnt_valid=%b want 0", k, bus.gnt_valid);
            end
            drive(3'b111, 1'b1, 1'b0);
            checks++;
            if (bus.gnt_valid !== 1'b1 || bus.grant !== exp_g[k] || bus.s_cyc !== 1'b1
                || bus.m_ack !== (3'b001 << exp_g[k])) begin
                failures++;
                $display("FAIL rr_grant k%0d: gnt_valid=%b grant=%0d s_cyc=%b ack=%b want 1 %0d 1 %b",
                         k, bus.gnt_valid, bus.grant, bus.s_cyc, bus.m_ack,
                         exp_g[k], 3'b001 << exp_g[k]);
            end
            cyc = 3'b111;
            cyc[exp_g[k]] = 1'b0;
            drive(cyc, 1'b0, 1'b0);
            checks++;
            if (bus.s_cyc !== 1'b0 || bus.m_ack !== 3'b000) begin
                failures++;
                $display("FAIL rr_release k%0d: s_cyc=%b ack=%b want 0 000", k, bus.s_cyc, bus.m_ack);
            end
        end
        drive(3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_multi_ack();
        int pulses = 0;
        logic ack;
        drive(3'b010, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            ack = (j % 2 == 0);
            drive(3'b011, ack, 1'b0);
            if (bus.m_ack[1] === 1'b1) pulses++;
            checks++;
            if (bus.gnt_valid !== 1'b1 || bus.grant !== 2'd1
                || bus.m_ack !== (ack ? 3'b010 : 3'b000) || bus.m_err !== 3'b000) begin
                failures++;
                $display("FAIL multi_ack j%0d: gnt_valid=%b grant=%0d ack=%b err=%b want 1 1 %b 000",
                         j, bus.gnt_valid, bus.grant, bus.m_ack, bus.m_err,
                         ack ? 3'b010 : 3'b000);
            end
        end
        checks++;
        if (pulses != 4) begin
            failures++;
            $display("FAIL multi_ack_count: pulses=%0d want 4", pulses);
        end
        drive(3'b001, 1'b0, 1'b0);
        checks++;
        if (bus.s_cyc !== 1'b0 || bus.grant !== 2'd1) begin
            failures++;
            $display("FAIL multi_release: s_cyc=%b grant=%0d want 0 1", bus.s_cyc, bus.grant);
        end
        drive(3'b001, 1'b0, 1'b0);
        checks++;
        if (bus.gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL multi_dead: gnt_valid=%b want 0", bus.gnt_valid);
        end
        drive(3'b001, 1'b0, 1'b0);
        checks++;
        if (bus.gnt_valid !== 1'b1 || bus.grant !== 2'd0) begin
            failures++;
            $display("FAIL multi_next: gnt_valid=%b grant=%0d want 1 0", bus.gnt_valid, bus.grant);
        end
        drive(3'b000, 1'b0, 1'b0);
        drive(3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_error();
        drive(3'b100, 1'b0, 1'b0);
        drive(3'b100, 1'b0, 1'b1);
        checks++;
        if (bus.grant !== 2'd2 || bus.m_err !== 3'b100 || bus.m_ack !== 3'b000) begin
            failures++;
            $display("FAIL err_route: grant=%0d err=%b ack=%b want 2 100 000",
                     bus.grant, bus.m_err, bus.m_ack);
        end
        drive(3'b000, 1'b0, 1'b0);
        checks++;
        if (bus.m_err !== 3'b000) begin
            failures++;
            $display("FAIL err_clear: err=%b want 000", bus.m_err);
        end
        drive(3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_watchdog();
        logic [2:0] exp_err;
        drive(3'b001, 1'b0, 1'b0);
        for (int j = 1; j <= 100; j++) begin
            drive(3'b001, 1'b0, 1'b0);
            exp_err = (TO_EN && (j % 11 == 0)) ? 3'b001 : 3'b000;
            checks++;
            if (bus.m_err !== exp_err || bus.grant !== 2'd0) begin
                failures++;
                $display("FAIL watchdog j%0d: err=%b grant=%0d want %b 0",
                         j, bus.m_err, bus.grant, exp_err);
            end
        end
        drive(3'b000, 1'b0, 1'b0);
        drive(3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive(3'b010, 1'b0, 1'b0);
        drive(3'b000, 1'b0, 1'b0);
        drive(3'b000, 1'b0, 1'b0);
        drive(3'b010, 1'b0, 1'b0);
        drive(3'b010, 1'b0, 1'b0);
        checks++;
        if (bus.gnt_valid !== 1'b1 || bus.grant !== 2'd1) begin
            failures++;
            $display("FAIL rstmid_busy: gnt_valid=%b grant=%0d want 1 1", bus.gnt_valid, bus.grant);
        end
        rst = 1'b1;
        drive(3'b110, 1'b1, 1'b0);
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.grant !== 2'd0 || bus.s_cyc !== 1'b0
            || bus.m_ack !== 3'b000 || bus.m_err !== 3'b000) begin
            failures++;
            $display("FAIL rstmid_drop: gnt_valid=%b grant=%0d s_cyc=%b ack=%b err=%b want all 0",
                     bus.gnt_valid, bus.grant, bus.s_cyc, bus.m_ack, bus.m_err);
        end
        rst = 1'b0;
        drive(3'b110, 1'b0, 1'b0);
        checks++;
        if (bus.gnt_valid !== 1'b1 || bus.grant !== 2'd1) begin
            failures++;
            $display("FAIL rstmid_regrant: gnt_valid=%b grant=%0d want 1 1", bus.gnt_valid, bus.grant);
        end
        drive(3'b000, 1'b0, 1'b0);
        drive(3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        bus.m_cyc = 3'b000;
        bus.s_ack = 1'b0;
        bus.s_err = 1'b0;
        test_reset();
        test_round_robin();
        test_multi_ack();
        test_error();
        test_watchdog();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
